// File: rtl/multicycle_control.sv
// Multicycle sequencer for the LEGv8 core. Steps each instruction through
// fetch / decode / execute / memory / writeback. It owns the shared memory
// port through a req/ready handshake, counts retired instructions and traps
// on opcodes it cannot decode.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        readreg2_control,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EX_R    = 4'd2,
        EX_ADDR = 4'd3,
        EX_BR   = 4'd4,
        MEM_RD  = 4'd5,
        MEM_WR  = 4'd6,
        WB_R    = 4'd7,
        WB_LD   = 4'd8,
        TRAP    = 4'd9
    } state_t;

    state_t      state;
    logic [31:0] retired_q;
    logic        illegal_q;

    // Opcode classes; branch encodings carry immediate bits in the low field.
    logic is_r, is_ldur, is_stur, is_cbz, is_cbnz, is_b;
    assign is_r    = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                     (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
    assign is_ldur = (opcode == 11'b11111000010);
    assign is_stur = (opcode == 11'b11111000000);
    assign is_cbz  = (opcode[10:3] == 8'b10110100);
    assign is_cbnz = (opcode[10:3] == 8'b10110101);
    assign is_b    = (opcode[10:5] == 6'b000101);

    // State sequencing, retire counting and the sticky trap flag.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                FETCH:   if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (is_r)                     state <= EX_R;
                    else if (is_ldur || is_stur)  state <= EX_ADDR;
                    else if (is_cbz || is_cbnz || is_b) state <= EX_BR;
                    else begin
                        state     <= TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                EX_R:    state <= WB_R;
                EX_ADDR: state <= is_ldur ? MEM_RD : MEM_WR;
                EX_BR: begin
                    state     <= FETCH;
                    retired_q <= retired_q + 32'd1;
                end
                MEM_RD:  if (mem_ready) state <= WB_LD;
                MEM_WR: begin
                    if (mem_ready) begin
                        state     <= FETCH;
                        retired_q <= retired_q + 32'd1;
                    end
                end
                WB_R, WB_LD: begin
                    state     <= FETCH;
                    retired_q <= retired_q + 32'd1;
                end
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Control decode: Moore on state, except the fetch load enables (follow
    // mem_ready) and the branch PC load (follows zero). All forced low in reset.
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        addr_sel         = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        readreg2_control = 1'b0;
        alu_src          = 1'b0;
        mem_to_reg       = 1'b0;
        reg_write        = 1'b0;
        alu_op           = 2'b00;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                EX_R: begin
                    alu_op = 2'b10;
                end
                EX_ADDR: begin
                    alu_src          = 1'b1;
                    readreg2_control = is_stur;
                end
                EX_BR: begin
                    alu_op           = 2'b01;
                    pc_src           = 1'b1;
                    readreg2_control = is_cbz || is_cbnz;
                    pc_write         = is_b || (is_cbz && zero) || (is_cbnz && !zero);
                end
                MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                MEM_WR: begin
                    mem_req          = 1'b1;
                    addr_sel         = 1'b1;
                    mem_we           = 1'b1;
                    readreg2_control = 1'b1;
                end
                WB_R: begin
                    reg_write = 1'b1;
                end
                WB_LD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign state_dbg = state;

endmodule
